// File: rtl/astro_rom_loader.sv
// HPS ioctl download responder for the Astrocade core: splits 16-bit words into byte writes
// for the cart/BIOS RAMs, tracks cart size and mirrors short cart images across the window.
module astro_rom_loader #(
  parameter int         ADDR_W   = 13,
  parameter logic [7:0] IDX_BIOS = 8'd0,
  parameter logic [7:0] IDX_CART = 8'd1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [15:0]       ioctl_dout,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_q,
  output logic              cart_we,
  output logic              bios_we,
  output logic [ADDR_W:0]   cart_size,
  output logic              load_done
);

  localparam logic [24:0]       WIN25  = 25'(2**ADDR_W);
  localparam logic [ADDR_W:0]   WIN_SZ = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   TWO    = {{(ADDR_W-1){1'b0}}, 2'b10};
  localparam logic [ADDR_W-1:0] ONE_A  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] LAST_A = '1;

  typedef enum logic [2:0] {IDLE, LOAD, WR_LO, WR_HI, MIR_RD, MIR_WR, DONE} state_t;

  state_t            state_q, state_d;
  logic [15:0]       word_q, word_d;
  logic [24:0]       addr_q, addr_d;
  logic              cart_tgt_q, cart_tgt_d;
  logic              wait_q, wait_d;
  logic              cart_we_q, cart_we_d;
  logic              bios_we_q, bios_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_din_q, mem_din_d;
  logic [ADDR_W:0]   cart_size_q, cart_size_d;
  logic              load_done_q, load_done_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;

  logic              is_cart_idx, is_bios_idx;
  logic              in_win_lo, in_win_hi;
  logic              start_load;
  logic [ADDR_W:0]   size_cand;
  logic [ADDR_W-1:0] src_inc, src_next;

  always_comb begin
    is_cart_idx = (ioctl_index == IDX_CART);
    is_bios_idx = (ioctl_index == IDX_BIOS);
    in_win_lo   = (ioctl_addr < WIN25);
    in_win_hi   = (addr_q < (WIN25 - 25'd1));
    start_load  = ioctl_download && (state_q inside {IDLE, DONE, MIR_RD, MIR_WR});
    size_cand   = (ioctl_addr >= (WIN25 - 25'd2)) ? WIN_SZ : (ioctl_addr[ADDR_W:0] + TWO);
    // Source pointer wraps at the loaded size so non-power-of-two images repeat correctly.
    src_inc     = src_q + ONE_A;
    src_next    = ({1'b0, src_inc} == cart_size_q) ? '0 : src_inc;
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    addr_d      = addr_q;
    cart_tgt_d  = cart_tgt_q;
    wait_d      = 1'b0;
    cart_we_d   = 1'b0;
    bios_we_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    cart_size_d = cart_size_q;
    load_done_d = load_done_q;
    src_d       = src_q;
    dst_d       = dst_q;

    if (start_load) begin
      state_d     = LOAD;
      load_done_d = 1'b0;
      cart_tgt_d  = is_cart_idx;
      if (is_cart_idx) cart_size_d = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (!ioctl_download) begin
            if (cart_tgt_q && (cart_size_q != '0) && (cart_size_q < WIN_SZ)) begin
              state_d    = MIR_RD;
              src_d      = '0;
              dst_d      = cart_size_q[ADDR_W-1:0];
              mem_addr_d = '0;
            end else begin
              state_d     = DONE;
              load_done_d = 1'b1;
            end
          end else if (ioctl_wr && (is_cart_idx || is_bios_idx)) begin
            state_d    = WR_LO;
            word_d     = ioctl_dout;
            addr_d     = ioctl_addr;
            cart_tgt_d = is_cart_idx;
            wait_d     = 1'b1;
            mem_addr_d = ioctl_addr[ADDR_W-1:0];
            mem_din_d  = ioctl_dout[7:0];
            cart_we_d  = is_cart_idx && in_win_lo;
            bios_we_d  = is_bios_idx && in_win_lo;
            if (is_cart_idx && (size_cand > cart_size_q)) cart_size_d = size_cand;
          end
        end
        WR_LO: begin
          state_d    = WR_HI;
          wait_d     = 1'b1;
          mem_addr_d = addr_q[ADDR_W-1:0] + ONE_A;
          mem_din_d  = word_q[15:8];
          cart_we_d  = cart_tgt_q && in_win_hi;
          bios_we_d  = !cart_tgt_q && in_win_hi;
        end
        WR_HI: state_d = LOAD;
        MIR_RD: begin
          state_d    = MIR_WR;
          mem_addr_d = dst_q;
          cart_we_d  = 1'b1;
        end
        MIR_WR: begin
          if (dst_q == LAST_A) begin
            state_d     = DONE;
            load_done_d = 1'b1;
          end else begin
            state_d    = MIR_RD;
            src_d      = src_next;
            dst_d      = dst_q + ONE_A;
            mem_addr_d = src_next;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      word_q      <= '0;
      addr_q      <= '0;
      cart_tgt_q  <= 1'b0;
      wait_q      <= 1'b0;
      cart_we_q   <= 1'b0;
      bios_we_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      cart_size_q <= '0;
      load_done_q <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      cart_tgt_q  <= cart_tgt_d;
      wait_q      <= wait_d;
      cart_we_q   <= cart_we_d;
      bios_we_q   <= bios_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      cart_size_q <= cart_size_d;
      load_done_q <= load_done_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
    end
  end

  // RAM read data only arrives during MIR_WR, so it is forwarded straight to the write port.
  assign mem_din    = (state_q == MIR_WR) ? mem_q : mem_din_q;
  assign ioctl_wait = wait_q;
  assign mem_addr   = mem_addr_q;
  assign cart_we    = cart_we_q;
  assign bios_we    = bios_we_q;
  assign cart_size  = cart_size_q;
  assign load_done  = load_done_q;

endmodule

// File: tb/tb_astro_rom_loader.sv
// Self-checking bench for astro_rom_loader: random download images against a byte-level
// reference of what the cart/BIOS RAMs must hold, plus timing and size checks.
module tb_astro_rom_loader;

  localparam int AW  = 13;
  localparam int WIN = 8192;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ioctl_download;
  logic [7:0]    ioctl_index;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [15:0]   ioctl_dout;
  logic          ioctl_wait;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [7:0]    memQ;
  logic          cart_we;
  logic          bios_we;
  logic [AW:0]   cart_size;
  logic          load_done;

  always #5 clk_sys = ~clk_sys;

  astro_rom_loader #(.ADDR_W(AW), .IDX_BIOS(8'd0), .IDX_CART(8'd1)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_q(memQ), .cart_we(cart_we), .bios_we(bios_we),
    .cart_size(cart_size), .load_done(load_done)
  );

  // Two synchronous RAMs as the dpram instances would behave; cart read data is one cycle late.
  logic [7:0] cartRam [WIN];
  logic [7:0] biosRam [WIN];
  int cartWeCnt = 0;
  int biosWeCnt = 0;

  always @(posedge clk_sys) begin
    if (cart_we) begin
      cartRam[mem_addr] <= mem_din;
      cartWeCnt <= cartWeCnt + 1;
    end
    if (bios_we) begin
      biosRam[mem_addr] <= mem_din;
      biosWeCnt <= biosWeCnt + 1;
    end
    memQ <= cartRam[mem_addr];
  end

  // Reference model: expected RAM images and expected cart size.
  logic [7:0] expCart [WIN];
  logic [7:0] expBios [WIN];
  int expSize = 0;
  bit lastCart = 1'b0;
  int checks = 0;
  int errors = 0;

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, ":wait"},      32'(ioctl_wait), 32'd0);
    checkOutput({tag, ":cart_we"},   32'(cart_we),    32'd0);
    checkOutput({tag, ":bios_we"},   32'(bios_we),    32'd0);
    checkOutput({tag, ":load_done"}, 32'(load_done),  32'd0);
    checkOutput({tag, ":mem_addr"},  32'(mem_addr),   32'd0);
    checkOutput({tag, ":mem_din"},   32'(mem_din),    32'd0);
    checkOutput({tag, ":cart_size"}, 32'(cart_size),  32'd0);
  endtask

  task automatic startDownload(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    lastCart       = (idx == 8'd1);
    if (idx == 8'd1) expSize = 0;
    tick;
  endtask

  task automatic applyStimulus(input logic [7:0] idx, input int addr, input logic [15:0] data,
                               output int waitCycles);
    ioctl_addr = 25'(addr);
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    tick;
    ioctl_wr   = 1'b0;
    waitCycles = 0;
    while (ioctl_wait === 1'b1 && waitCycles < 10) begin
      waitCycles++;
      tick;
    end
    if (idx == 8'd1 || idx == 8'd0) begin
      if (addr < WIN) begin
        if (idx == 8'd1) begin
          expCart[addr]     = data[7:0];
          expCart[addr + 1] = data[15:8];
        end else begin
          expBios[addr]     = data[7:0];
          expBios[addr + 1] = data[15:8];
        end
      end
      if (idx == 8'd1) expSize = (addr + 2 > WIN) ? ((expSize > WIN) ? expSize : WIN)
                                                  : ((expSize > addr + 2) ? expSize : addr + 2);
    end
    if ($urandom_range(0, 7) == 0) tick;
  endtask

  task automatic loadImage(input logic [7:0] idx, input int nbytes, output int badWait);
    int w;
    badWait = 0;
    for (int a = 0; a < nbytes; a += 2) begin
      applyStimulus(idx, a, 16'($urandom), w);
      if (w != 2) badWait++;
    end
  endtask

  task automatic finishDownload(input string tag);
    int mir;
    int expLat;
    int lat;
    mir = (lastCart && expSize > 0 && expSize < WIN) ? (WIN - expSize) : 0;
    for (int n = expSize; n < WIN && mir > 0; n++) expCart[n] = expCart[n % expSize];
    expLat = 2 * mir + 1;
    ioctl_download = 1'b0;
    lat = 0;
    while (load_done !== 1'b1 && lat < expLat + 50) begin
      tick;
      lat++;
    end
    checkOutput({tag, ":done_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, ":load_done"}, 32'(load_done), 32'd1);
  endtask

  task automatic compareRam(input string tag, input bit isCart);
    int bad;
    bad = 0;
    for (int n = 0; n < WIN; n++) begin
      if (isCart) begin
        if (cartRam[n] !== expCart[n]) bad++;
      end else begin
        if (biosRam[n] !== expBios[n]) bad++;
      end
    end
    checkOutput({tag, ":ram_bad_bytes"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int w;
    int bad;
    int c0;
    int b0;
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    tick;
    tick;
    checkIdleOutputs("reset");
    reset = 1'b0;
    tick;
    checkIdleOutputs("idle");

    $display("[TB] two-word cart");
    startDownload(8'd1);
    applyStimulus(8'd1, 0, 16'h3412, w);
    checkOutput("t1:wait_w0", 32'(w), 32'd2);
    applyStimulus(8'd1, 2, 16'h7856, w);
    checkOutput("t1:wait_w1", 32'(w), 32'd2);
    checkOutput("t1:cart_size", 32'(cart_size), 32'd4);
    finishDownload("t1");
    checkOutput("t1:ram0", 32'(cartRam[0]), 32'h12);
    checkOutput("t1:ram1", 32'(cartRam[1]), 32'h34);
    checkOutput("t1:ram2", 32'(cartRam[2]), 32'h56);
    checkOutput("t1:ram3", 32'(cartRam[3]), 32'h78);
    checkOutput("t1:mirror4", 32'(cartRam[4]), 32'h12);
    compareRam("t1", 1'b1);

    $display("[TB] 4 KiB cart");
    startDownload(8'd1);
    loadImage(8'd1, 4096, bad);
    checkOutput("t2:bad_wait", 32'(bad), 32'd0);
    checkOutput("t2:cart_size", 32'(cart_size), 32'd4096);
    finishDownload("t2");
    compareRam("t2", 1'b1);

    $display("[TB] 6 KiB cart");
    startDownload(8'd1);
    loadImage(8'd1, 6144, bad);
    checkOutput("t3:bad_wait", 32'(bad), 32'd0);
    checkOutput("t3:cart_size", 32'(cart_size), 32'd6144);
    finishDownload("t3");
    compareRam("t3", 1'b1);

    $display("[TB] 8 KiB BIOS");
    c0 = cartWeCnt;
    b0 = biosWeCnt;
    startDownload(8'd0);
    loadImage(8'd0, 8192, bad);
    checkOutput("t4:bad_wait", 32'(bad), 32'd0);
    finishDownload("t4");
    checkOutput("t4:cart_writes", 32'(cartWeCnt - c0), 32'd0);
    checkOutput("t4:bios_writes", 32'(biosWeCnt - b0), 32'd8192);
    checkOutput("t4:cart_size", 32'(cart_size), 32'd6144);
    compareRam("t4_bios", 1'b0);
    compareRam("t4_cart", 1'b1);

    $display("[TB] window edge");
    c0 = cartWeCnt;
    startDownload(8'd1);
    applyStimulus(8'd1, 8190, 16'($urandom), w);
    checkOutput("t5:wait_8190", 32'(w), 32'd2);
    applyStimulus(8'd1, 8192, 16'($urandom), w);
    checkOutput("t5:wait_8192", 32'(w), 32'd2);
    checkOutput("t5:cart_writes", 32'(cartWeCnt - c0), 32'd2);
    checkOutput("t5:cart_size", 32'(cart_size), 32'd8192);
    finishDownload("t5");
    compareRam("t5", 1'b1);

    $display("[TB] unknown index");
    c0 = cartWeCnt;
    b0 = biosWeCnt;
    startDownload(8'd2);
    applyStimulus(8'd2, 0, 16'hBEEF, w);
    checkOutput("t6:wait", 32'(w), 32'd0);
    checkOutput("t6:writes", 32'((cartWeCnt - c0) + (biosWeCnt - b0)), 32'd0);
    finishDownload("t6");
    checkOutput("t6:cart_size", 32'(cart_size), 32'd8192);

    $display("[TB] reset during mirror");
    startDownload(8'd1);
    loadImage(8'd1, 100, bad);
    ioctl_download = 1'b0;
    for (int i = 0; i < 40; i++) tick;
    w = 0;
    while (cart_we !== 1'b1 && w < 4) begin
      tick;
      w++;
    end
    checkOutput("t7:in_mir_wr", 32'(cart_we), 32'd1);
    reset = 1'b1;
    tick;
    checkIdleOutputs("t7_reset");
    reset = 1'b0;
    tick;
    checkIdleOutputs("t7_after");
    startDownload(8'd1);
    loadImage(8'd1, 3000, bad);
    checkOutput("t7:bad_wait", 32'(bad), 32'd0);
    checkOutput("t7:cart_size", 32'(cart_size), 32'd3000);
    finishDownload("t7");
    compareRam("t7", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
